// File: rtl/key_perm_reg.sv
// key_perm_reg: registered fixed 64-bit bit permutation for the DVB-CSA key schedule.
// A word captured with i_valid appears permuted on o_key one clock later.
module key_perm_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_valid,
  input  logic [63:0] i_key,
  output logic        o_valid,
  output logic [63:0] o_key
);
  // 1-based destination bit for each source bit j
  localparam logic [6:0] P [64] = '{
    7'h12, 7'h24, 7'h09, 7'h07, 7'h2A, 7'h31, 7'h1D, 7'h15,
    7'h1C, 7'h36, 7'h3E, 7'h32, 7'h13, 7'h21, 7'h3B, 7'h40,
    7'h18, 7'h14, 7'h25, 7'h27, 7'h02, 7'h35, 7'h1B, 7'h01,
    7'h22, 7'h04, 7'h0D, 7'h0E, 7'h39, 7'h28, 7'h1A, 7'h29,
    7'h33, 7'h23, 7'h34, 7'h0C, 7'h16, 7'h30, 7'h1E, 7'h3A,
    7'h2D, 7'h1F, 7'h08, 7'h19, 7'h17, 7'h2F, 7'h3D, 7'h11,
    7'h3C, 7'h05, 7'h38, 7'h2B, 7'h0B, 7'h06, 7'h0A, 7'h2C,
    7'h20, 7'h3F, 7'h2E, 7'h0F, 7'h03, 7'h26, 7'h10, 7'h37
  };
  logic [63:0] perm;
  logic [63:0] key_d, key_q;
  logic        valid_d, valid_q;
  for (genvar g = 0; g < 64; g++) begin : g_perm
    assign perm[P[g][5:0] - 6'd1] = i_key[g];
  end
  always_comb begin
    key_d   = i_valid ? perm : key_q;
    valid_d = i_valid;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q   <= 64'h0;
      valid_q <= 1'b0;
    end else begin
      key_q   <= key_d;
      valid_q <= valid_d;
    end
  end
  assign o_key   = key_q;
  assign o_valid = valid_q;
endmodule

// File: tb/tb_key_perm_reg.sv
// tb_key_perm_reg: directed, table-driven self-checking bench for key_perm_reg.
module tb_key_perm_reg;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic [63:0] i_key = 64'h0;
  logic        o_valid;
  logic [63:0] o_key;
  int n_cmp = 0;
  int n_err = 0;

  key_perm_reg dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_key(i_key),
    .o_valid(o_valid), .o_key(o_key)
  );

  always #5 clk = ~clk;

  int tp [64] = '{
    'h12, 'h24, 'h09, 'h07, 'h2A, 'h31, 'h1D, 'h15,
    'h1C, 'h36, 'h3E, 'h32, 'h13, 'h21, 'h3B, 'h40,
    'h18, 'h14, 'h25, 'h27, 'h02, 'h35, 'h1B, 'h01,
    'h22, 'h04, 'h0D, 'h0E, 'h39, 'h28, 'h1A, 'h29,
    'h33, 'h23, 'h34, 'h0C, 'h16, 'h30, 'h1E, 'h3A,
    'h2D, 'h1F, 'h08, 'h19, 'h17, 'h2F, 'h3D, 'h11,
    'h3C, 'h05, 'h38, 'h2B, 'h0B, 'h06, 'h0A, 'h2C,
    'h20, 'h3F, 'h2E, 'h0F, 'h03, 'h26, 'h10, 'h37
  };

  function automatic logic [63:0] model(input logic [63:0] k);
    logic [63:0] r = 64'h0;
    for (int j = 0; j < 64; j++) r[tp[j] - 1] = k[j];
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [63:0] k);
    i_valid = v;
    i_key   = k;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [63:0] key;
    logic [63:0] exp;
  } vec_t;

  initial begin
    vec_t vecs [5];
    logic [63:0] seen, m, start;
    vecs[0] = '{64'h1,                   64'h0000_0000_0002_0000};
    vecs[1] = '{64'h0000_0000_0000_8000, 64'h8000_0000_0000_0000};
    vecs[2] = '{64'h0000_0000_0080_0000, 64'h1};
    vecs[3] = '{64'h0,                   64'h0};
    vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};

    #3;
    chk("reset_key", o_key, 64'h0);
    chk("reset_valid", {63'h0, o_valid}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      step(1'b1, vecs[i].key);
      chk($sformatf("vec%0d_key", i), o_key, vecs[i].exp);
      chk($sformatf("vec%0d_valid", i), {63'h0, o_valid}, 64'h1);
    end

    seen = 64'h0;
    for (int j = 0; j < 64; j++) begin
      step(1'b1, 64'h1 << j);
      chk($sformatf("walk%0d", j), o_key, 64'h1 << (tp[j] - 1));
      if (o_valid !== 1'b1) chk($sformatf("walk%0d_valid", j), {63'h0, o_valid}, 64'h1);
      seen |= o_key;
    end
    chk("walk_distinct", seen, 64'hFFFF_FFFF_FFFF_FFFF);

    step(1'b1, 64'h1);
    chk("hold_cap_key", o_key, 64'h0000_0000_0002_0000);
    chk("hold_cap_valid", {63'h0, o_valid}, 64'h1);
    step(1'b0, 64'hDEAD_BEEF_0000_0000);
    chk("hold1_key", o_key, 64'h0000_0000_0002_0000);
    chk("hold1_valid", {63'h0, o_valid}, 64'h0);
    step(1'b0, 64'hDEAD_BEEF_0000_0000);
    chk("hold2_key", o_key, 64'h0000_0000_0002_0000);
    chk("hold2_valid", {63'h0, o_valid}, 64'h0);

    start = {$urandom, $urandom};
    m = start;
    i_key = start;
    for (int s = 0; s < 7; s++) begin
      step(1'b1, i_key);
      m = model(m);
      chk($sformatf("chain%0d", s), o_key, m);
      chk($sformatf("chain%0d_pop", s), 64'($countones(o_key)), 64'($countones(start)));
      i_key = o_key;
    end

    step(1'b1, 64'h0000_0000_0000_8000);
    chk("pre_rst_valid", {63'h0, o_valid}, 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_key", o_key, 64'h0);
    chk("async_rst_valid", {63'h0, o_valid}, 64'h0);
    @(posedge clk);
    #1;
    chk("rst_held_key", o_key, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 64'h0000_0000_0080_0000);
    chk("post_rst_key", o_key, 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
